firebird7_in_gate1_tessent_tdr_w3_ctl: RTL

IJTAG test data register (TDR) that drives the control side of the 3-bit instrument data mux in gate1. It produces the mux select and the IJTAG data word from a shift/update register pair, and captures functional data, or reads back its own outputs, for observation on the scan path. It sits on the gate1 IJTAG network as one SIB-gated segment, clocked by the network clock.

---
 rtl/firebird7_in_gate1_tessent_tdr_w3_ctl.sv | 63 ++++++
 1 files changed

// File: rtl/firebird7_in_gate1_tessent_tdr_w3_ctl.sv
// IJTAG TDR for the gate1 instrument data mux: shift/update pair producing the
// mux select and data word, with functional or readback capture onto the scan path.
module firebird7_in_gate1_tessent_tdr_w3_ctl #(
    parameter int unsigned              DATA_WIDTH   = 3,
    parameter logic [DATA_WIDTH-1:0]    RESET_DATA   = '0,
    parameter logic                     RESET_SELECT = 1'b0,
    parameter logic                     CAPTURE_SRC  = 1'b0
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    input  logic                  ijtag_si,
    output logic                  ijtag_so,
    input  logic [DATA_WIDTH-1:0] functional_data_in,
    output logic                  ijtag_select,
    output logic [DATA_WIDTH-1:0] ijtag_data_out
);

    localparam int unsigned SCAN_LEN = DATA_WIDTH + 1;

    // Bit DATA_WIDTH of both registers is the mux select; the low bits are data.
    logic [SCAN_LEN-1:0]   sr_q, sr_d;
    logic [SCAN_LEN-1:0]   ur_q, ur_d;
    logic [DATA_WIDTH-1:0] capture_data;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        sr_d         = sr_q;
        ur_d         = ur_q;
        capture_data = CAPTURE_SRC ? ur_q[DATA_WIDTH-1:0] : functional_data_in;

        // Capture beats shift beats update; a deselected segment holds everything.
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_d = {ur_q[DATA_WIDTH], capture_data};
            end else if (ijtag_se) begin
                sr_d = {ijtag_si, sr_q[SCAN_LEN-1:1]};
            end else if (ijtag_ue) begin
                ur_d = sr_q;
            end
        end
    end

    always_ff @(posedge ijtag_tck) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (ijtag_reset) begin
            sr_q <= '0;
            ur_q <= {RESET_SELECT, RESET_DATA};
        end else begin
            sr_q <= sr_d;
            ur_q <= ur_d;
        end
    end

    // Outputs come straight from the update flops, so they stay quiet while shifting.
    assign ijtag_so       = sr_q[0];
    assign ijtag_select   = ur_q[DATA_WIDTH];
    assign ijtag_data_out = ur_q[DATA_WIDTH-1:0];

endmodule
